// File: rtl/led_sequence_ctrl_pkg.sv
// Shared definitions for the LED column-fill sequencer: state encoding,
// the phase-to-LED pattern table and the phase wrap point.
package led_sequence_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned LED_W   = 16;
    localparam int unsigned PHASE_W = 3;

    // Columns fill from the MSB of each nibble downwards.
    localparam logic [LED_W-1:0] PH_LED0 = 16'h0000;
    localparam logic [LED_W-1:0] PH_LED1 = 16'h8888;
    localparam logic [LED_W-1:0] PH_LED2 = 16'hCCCC;
    localparam logic [LED_W-1:0] PH_LED3 = 16'hEEEE;
    localparam logic [LED_W-1:0] PH_LED4 = 16'hFFFF;
    localparam logic [LED_W-1:0] PH_LED5 = 16'h0000;

    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd5;

    function automatic logic [LED_W-1:0] phase_led(input logic [PHASE_W-1:0] ph);
        logic [LED_W-1:0] pat;
        case (ph)
            3'd1:    pat = PH_LED1;
            3'd2:    pat = PH_LED2;
            3'd3:    pat = PH_LED3;
            3'd4:    pat = PH_LED4;
            3'd5:    pat = PH_LED5;
            default: pat = PH_LED0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: emits a one-cycle tick every 2^FAST_DIV or 2^SLOW_DIV
// counting cycles; the count is preserved across pauses and speed changes.
module led_tick_gen #(
    parameter int unsigned FAST_DIV = 25,
    parameter int unsigned SLOW_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    input  logic speed,
    output logic tick
);

    localparam logic [SLOW_DIV-1:0] FAST_TERM = SLOW_DIV'({FAST_DIV{1'b1}});
    localparam logic [SLOW_DIV-1:0] SLOW_TERM = {SLOW_DIV{1'b1}};

    logic [SLOW_DIV-1:0] cnt_q;
    logic [SLOW_DIV-1:0] cnt_d;
    logic [SLOW_DIV-1:0] term;

    // >= rather than == so a slow-to-fast switch past the fast terminal ticks at once.
    always_comb begin
        term  = speed ? FAST_TERM : SLOW_TERM;
        tick  = cnt_en && (cnt_q >= term);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + SLOW_DIV'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequence_ctrl.sv
// LED column-fill sequencer: start/stop/pause control, phase stepping on
// prescaler ticks, loop counting with a one-cycle completion pulse.
module led_sequence_ctrl
    import led_sequence_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV = 25,
    parameter int unsigned SLOW_DIV = 27,
    parameter int unsigned REPEAT   = 3,
    parameter int unsigned LOOP_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        en,
    input  logic        speed,
    output logic [15:0] led,
    output logic [2:0]  phase,
    output logic        busy,
    output logic        done
);

    localparam bit                FINITE    = (REPEAT != 0);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(FINITE ? REPEAT - 1 : 0);

    state_e               state_q;
    state_e               state_d;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic [LED_W-1:0]     led_q;
    logic [LED_W-1:0]     led_d;
    logic [LOOP_W-1:0]    loop_q;
    logic [LOOP_W-1:0]    loop_d;
    logic                 done_q;
    logic                 done_d;

    logic                 tick;
    logic                 launch;
    logic                 cnt_en;

    assign launch = (state_q == IDLE) && start && !stop;
    assign cnt_en = (state_q == RUN) && en && !stop;

    led_tick_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .cnt_en (cnt_en),
        .speed  (speed),
        .tick   (tick)
    );

    // Next-state, phase, LED and loop bookkeeping.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        led_d   = led_q;
        loop_d  = loop_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                    phase_d = '0;
                    led_d   = PH_LED0;
                    loop_d  = '0;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                    led_d   = PH_LED0;
                end else if (!en) begin
                    state_d = HOLD;
                end else if (tick) begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        led_d   = PH_LED0;
                        if (FINITE && (loop_q == LOOP_LAST)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (loop_q != {LOOP_W{1'b1}}) begin
                            loop_d = loop_q + LOOP_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                        led_d   = phase_led(phase_q + PHASE_W'(1));
                    end
                end
            end

            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                    led_d   = PH_LED0;
                end else if (en) begin
                    state_d = RUN;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            led_q   <= '0;
            loop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    assign led   = led_q;
    assign phase = phase_q;
    assign done  = done_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Bench for led_sequence_ctrl: a REPEAT=2 instance and a REPEAT=0 instance
// checked cycle by cycle against a behavioural model of the sequencing rules.
module tb_led_sequence_ctrl;

    localparam int unsigned FDIV = 2;
    localparam int unsigned SDIV = 4;

    logic        clk;
    logic        a_rst, a_start, a_stop, a_en, a_speed;
    logic [15:0] a_led;
    logic [2:0]  a_phase;
    logic        a_busy, a_done;
    logic        b_rst, b_start, b_stop, b_en, b_speed;
    logic [15:0] b_led;
    logic [2:0]  b_phase;
    logic        b_busy, b_done;

    int n_cmp;
    int n_err;

    led_sequence_ctrl #(.FAST_DIV(FDIV), .SLOW_DIV(SDIV), .REPEAT(2), .LOOP_W(8)) dut (
        .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop), .en(a_en), .speed(a_speed),
        .led(a_led), .phase(a_phase), .busy(a_busy), .done(a_done)
    );

    led_sequence_ctrl #(.FAST_DIV(FDIV), .SLOW_DIV(SDIV), .REPEAT(0), .LOOP_W(8)) dut_inf (
        .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .en(b_en), .speed(b_speed),
        .led(b_led), .phase(b_phase), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one entry per instance.
    int m_phase [2];
    int m_cnt   [2];
    int m_loops [2];
    bit m_busy  [2];
    bit m_paused[2];
    bit m_done  [2];

    function automatic int repeat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_step(input int i, input bit rst, input bit start, input bit stop,
                              input bit en, input bit speed);
        int term;
        bit was_done;
        if (rst) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_loops[i] = 0;
            m_busy[i] = 0; m_paused[i] = 0; m_done[i] = 0;
            return;
        end
        was_done  = m_done[i];
        m_done[i] = 0;
        term = speed ? (1 << FDIV) - 1 : (1 << SDIV) - 1;
        if (was_done) begin
            // completion cycle always returns to idle
        end else if (!m_busy[i]) begin
            if (start && !stop) begin
                m_busy[i] = 1; m_paused[i] = 0;
                m_phase[i] = 0; m_loops[i] = 0; m_cnt[i] = 0;
            end
        end else if (stop) begin
            m_busy[i] = 0; m_paused[i] = 0; m_phase[i] = 0;
        end else if (m_paused[i]) begin
            if (en) m_paused[i] = 0;
        end else if (!en) begin
            m_paused[i] = 1;
        end else if (m_cnt[i] >= term) begin
            m_cnt[i] = 0;
            if (m_phase[i] < 5) begin
                m_phase[i]++;
            end else begin
                m_phase[i] = 0;
                if (repeat_of(i) != 0 && m_loops[i] + 1 == repeat_of(i)) begin
                    m_busy[i] = 0; m_done[i] = 1;
                end else begin
                    m_loops[i]++;
                end
            end
        end else begin
            m_cnt[i]++;
        end
    endtask

    // Expected {led, phase, busy, done}; LED nibble = top p bits set.
    function automatic logic [20:0] exp_v(input int i);
        int p;
        logic [15:0] l;
        p = m_phase[i];
        if (p >= 1 && p <= 4) l = 16'((((1 << p) - 1) << (4 - p)) * 32'h1111);
        else                  l = 16'h0000;
        return {l, 3'(p), m_busy[i], m_done[i]};
    endfunction

    function automatic logic [20:0] act_v(input int i);
        if (i == 0) return {a_led, a_phase, a_busy, a_done};
        return {b_led, b_phase, b_busy, b_done};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step(0, a_rst, a_start, a_stop, a_en, a_speed);
        model_step(1, b_rst, b_start, b_stop, b_en, b_speed);
        #1;
    endtask

    task automatic go_idle();
        a_start = 0; a_stop = 1; step(); a_stop = 0;
        b_start = 0; b_stop = 1; step(); b_stop = 0;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1;
        a_start = 1; b_start = 1;
        step(); step();
        a_start = 0; b_start = 0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_v(i) !== 21'h0 || act_v(i) !== exp_v(i)) begin
                n_err++;
                $display("FAIL reset inst=%0d got=%h exp=%h", i, act_v(i), exp_v(i));
            end
        end
        a_rst = 0; b_rst = 0;
        step();
    endtask

    task automatic test_basic();
        int done_k;
        done_k = -1;
        a_en = 1; a_speed = 1; a_start = 1;
        step();
        a_start = 0;
        for (int k = 1; k <= 52; k++) begin
            step();
            n_cmp++;
            if (act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL basic k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
            if (a_done === 1'b1) done_k = k;
            if (k == 12) begin
                n_cmp++;
                if (a_led !== 16'hEEEE) begin
                    n_err++;
                    $display("FAIL basic_led12 got=%h exp=EEEE", a_led);
                end
            end
        end
        n_cmp++;
        if (done_k !== 48) begin
            n_err++;
            $display("FAIL basic_done_cycle got=%0d exp=48", done_k);
        end
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_end got=%b exp=0", a_busy);
        end
    endtask

    task automatic test_speed();
        a_en = 1; a_speed = 0; a_start = 1;
        step();
        a_start = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL speed_slow k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
        a_speed = 1;
        step();
        n_cmp++;
        if (a_phase !== 3'd1 || act_v(0) !== exp_v(0)) begin
            n_err++;
            $display("FAIL speed_switch got=%h exp=%h phase=%0d", act_v(0), exp_v(0), a_phase);
        end
        for (int k = 11; k <= 14; k++) begin
            step();
            n_cmp++;
            if (act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL speed_fast k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
        n_cmp++;
        if (a_phase !== 3'd2) begin
            n_err++;
            $display("FAIL speed_fast_step got=%0d exp=2", a_phase);
        end
        go_idle();
    endtask

    task automatic test_pause();
        a_en = 1; a_speed = 1; a_start = 1;
        step();
        a_start = 0;
        for (int k = 1; k <= 9; k++) step();
        a_en = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_cmp++;
            if (a_led !== 16'hCCCC || a_busy !== 1'b1 || act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL pause_hold k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
        a_en = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (a_phase !== ((k < 4) ? 3'd2 : 3'd3) || act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL pause_resume k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
        go_idle();
    endtask

    task automatic test_conflict();
        int n;
        a_en = 1; a_speed = 1; a_start = 1;
        step();
        a_start = 0;
        n = $urandom_range(5, 30);
        for (int k = 0; k < n; k++) step();
        a_start = 1; a_stop = 1;
        step();
        n_cmp++;
        if (a_busy !== 1'b0 || a_led !== 16'h0 || a_done !== 1'b0 || act_v(0) !== exp_v(0)) begin
            n_err++;
            $display("FAIL conflict_run got=%h exp=%h", act_v(0), exp_v(0));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (a_busy !== 1'b0 || act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL conflict_idle k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
        a_start = 0; a_stop = 0;
        step();
    endtask

    task automatic test_reset_mid();
        a_en = 1; a_speed = 1; a_start = 1;
        step();
        a_start = 0;
        for (int k = 1; k <= 16; k++) step();
        n_cmp++;
        if (a_phase !== 3'd4) begin
            n_err++;
            $display("FAIL rstmid_phase got=%0d exp=4", a_phase);
        end
        a_rst = 1; a_start = 1;
        step();
        a_rst = 0; a_start = 0;
        n_cmp++;
        if (act_v(0) !== 21'h0) begin
            n_err++;
            $display("FAIL rstmid_clear got=%h exp=000000", act_v(0));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (a_busy !== 1'b0 || act_v(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL rstmid_after k=%0d got=%h exp=%h", k, act_v(0), exp_v(0));
            end
        end
    endtask

    task automatic test_repeat0();
        int dones;
        dones = 0;
        b_en = 1; b_speed = 1; b_start = 1;
        step();
        b_start = 0;
        for (int k = 1; k <= 248; k++) begin
            step();
            n_cmp++;
            if (act_v(1) !== exp_v(1)) begin
                n_err++;
                $display("FAIL rep0 k=%0d got=%h exp=%h", k, act_v(1), exp_v(1));
            end
            if (b_done !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones !== 0 || b_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rep0_nodone dones=%0d busy=%b exp dones=0 busy=1", dones, b_busy);
        end
        b_stop = 1;
        step();
        b_stop = 0;
        n_cmp++;
        if (b_busy !== 1'b0 || act_v(1) !== exp_v(1)) begin
            n_err++;
            $display("FAIL rep0_stop got=%h exp=%h", act_v(1), exp_v(1));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            a_start = ($urandom_range(0, 19) == 0);
            a_stop  = ($urandom_range(0, 149) == 0);
            a_en    = ($urandom_range(0, 9) != 0);
            a_rst   = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) a_speed = ~a_speed;
            b_start = ($urandom_range(0, 19) == 0);
            b_stop  = ($urandom_range(0, 149) == 0);
            b_en    = ($urandom_range(0, 9) != 0);
            b_rst   = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) b_speed = ~b_speed;
            step();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (act_v(i) !== exp_v(i)) begin
                    n_err++;
                    $display("FAIL random inst=%0d k=%0d got=%h exp=%h", i, k, act_v(i), exp_v(i));
                end
            end
        end
        a_rst = 0; b_rst = 0;
        a_start = 0; b_start = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        a_rst = 1; a_start = 0; a_stop = 0; a_en = 0; a_speed = 1;
        b_rst = 1; b_start = 0; b_stop = 0; b_en = 0; b_speed = 1;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_loops[i] = 0;
            m_busy[i] = 0; m_paused[i] = 0; m_done[i] = 0;
        end
        #2;
        test_reset();
        test_basic();
        test_speed();
        test_pause();
        test_conflict();
        test_reset_mid();
        test_repeat0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
